// File: rtl/wb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : wb_commit_unit
// Brief    : Writeback/commit stage with registered GPR/CSR write pulses,
//            PC redirect with fetch bubble, retire counter and sticky halt.
// Revision : 1.0
// ============================================================================
module wb_commit_unit #(
  parameter int XLEN            = 32,
  parameter int RF_ADDR_W       = 4,
  parameter int CSR_ADDR_W      = 12,
  parameter int CNT_W           = 64,
  parameter int REDIRECT_BUBBLE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_pc,
  input  logic [XLEN-1:0]       in_res,
  input  logic [RF_ADDR_W-1:0]  in_rd_addr,
  input  logic                  in_rd_wen,
  input  logic [CSR_ADDR_W-1:0] in_csr_addr,
  input  logic                  in_csr_wen,
  input  logic [XLEN-1:0]       in_csr_wdata,
  input  logic [XLEN-1:0]       in_pc_next,
  input  logic                  in_jump,
  input  logic                  in_ecall,
  input  logic                  in_mret,
  input  logic                  in_ebreak,
  output logic                  rf_wen,
  output logic [RF_ADDR_W-1:0]  rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
  output logic                  csr_wen,
  output logic [CSR_ADDR_W-1:0] csr_waddr,
  output logic [XLEN-1:0]       csr_wdata,
  output logic                  redirect_valid,
  output logic [XLEN-1:0]       redirect_pc,
  output logic                  retire_valid,
  output logic [XLEN-1:0]       retire_pc,
  output logic [CNT_W-1:0]      instret,
  output logic                  halt
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_BUBBLE = 2'd1,
    S_HALT   = 2'd2
  } state_t;

  localparam logic [3:0] c_bubble = 4'(REDIRECT_BUBBLE);

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_bubble_cnt;
  logic [3:0]            w_bubble_cnt_next;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_redirect;

  logic                  r_rf_wen;
  logic [RF_ADDR_W-1:0]  r_rf_waddr;
  logic [XLEN-1:0]       r_rf_wdata;
  logic                  r_csr_wen;
  logic [CSR_ADDR_W-1:0] r_csr_waddr;
  logic [XLEN-1:0]       r_csr_wdata;
  logic                  r_redirect_valid;
  logic [XLEN-1:0]       r_redirect_pc;
  logic                  r_retire_valid;
  logic [XLEN-1:0]       r_retire_pc;
  logic [CNT_W-1:0]      r_instret;
  logic                  r_halt;

  // Ready is masked by reset so nothing can be handed over while it is held.
  assign w_ready    = (r_state == S_RUN) && !reset;
  assign w_accept   = in_valid && w_ready;
  assign w_redirect = (in_jump || in_ecall || in_mret) && !in_ebreak;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_bubble_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_next;
      r_bubble_cnt <= w_bubble_cnt_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_bubble_cnt_next = r_bubble_cnt;
    case (r_state)
      S_RUN: begin
        if (w_accept && in_ebreak) begin
          w_state_next = S_HALT;
        end else if (w_accept && w_redirect) begin
          w_state_next      = S_BUBBLE;
          w_bubble_cnt_next = c_bubble;
        end
      end
      S_BUBBLE: begin
        // Counter holds the number of not-ready cycles left including this one.
        if (r_bubble_cnt <= 4'd1) begin
          w_state_next      = S_RUN;
          w_bubble_cnt_next = 4'd0;
        end else begin
          w_bubble_cnt_next = r_bubble_cnt - 4'd1;
        end
      end
      S_HALT:  w_state_next = S_HALT;
      default: w_state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rf_wen         <= 1'b0;
      r_rf_waddr       <= '0;
      r_rf_wdata       <= '0;
      r_csr_wen        <= 1'b0;
      r_csr_waddr      <= '0;
      r_csr_wdata      <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
      r_retire_valid   <= 1'b0;
      r_retire_pc      <= '0;
      r_instret        <= '0;
      r_halt           <= 1'b0;
    end else begin
      r_rf_wen         <= w_accept && in_rd_wen && (in_rd_addr != '0);
      r_csr_wen        <= w_accept && in_csr_wen;
      r_redirect_valid <= w_accept && w_redirect;
      r_retire_valid   <= w_accept;
      if (w_accept) begin
        r_rf_waddr    <= in_rd_addr;
        r_rf_wdata    <= in_res;
        r_csr_waddr   <= in_csr_addr;
        r_csr_wdata   <= in_csr_wdata;
        r_redirect_pc <= in_pc_next;
        r_retire_pc   <= in_pc;
        r_instret     <= r_instret + CNT_W'(1);
      end
      if (w_accept && in_ebreak) begin
        r_halt <= 1'b1;
      end
    end
  end

  assign in_ready       = w_ready;
  assign rf_wen         = r_rf_wen;
  assign rf_waddr       = r_rf_waddr;
  assign rf_wdata       = r_rf_wdata;
  assign csr_wen        = r_csr_wen;
  assign csr_waddr      = r_csr_waddr;
  assign csr_wdata      = r_csr_wdata;
  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;
  assign retire_valid   = r_retire_valid;
  assign retire_pc      = r_retire_pc;
  assign instret        = r_instret;
  assign halt           = r_halt;

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_commit_unit
// Brief    : Directed and randomized bench for wb_commit_unit with a
//            cycle-indexed reference model.
// Revision : 1.0
// ============================================================================
module tb_wb_commit_unit;
  localparam int XLEN       = 32;
  localparam int RF_ADDR_W  = 4;
  localparam int CSR_ADDR_W = 12;
  localparam int CNT_W      = 4;
  localparam int BUBBLE     = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [XLEN-1:0]       in_pc = '0;
  logic [XLEN-1:0]       in_res = '0;
  logic [RF_ADDR_W-1:0]  in_rd_addr = '0;
  logic                  in_rd_wen = 1'b0;
  logic [CSR_ADDR_W-1:0] in_csr_addr = '0;
  logic                  in_csr_wen = 1'b0;
  logic [XLEN-1:0]       in_csr_wdata = '0;
  logic [XLEN-1:0]       in_pc_next = '0;
  logic                  in_jump = 1'b0;
  logic                  in_ecall = 1'b0;
  logic                  in_mret = 1'b0;
  logic                  in_ebreak = 1'b0;
  logic                  rf_wen;
  logic [RF_ADDR_W-1:0]  rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic                  csr_wen;
  logic [CSR_ADDR_W-1:0] csr_waddr;
  logic [XLEN-1:0]       csr_wdata;
  logic                  redirect_valid;
  logic [XLEN-1:0]       redirect_pc;
  logic                  retire_valid;
  logic [XLEN-1:0]       retire_pc;
  logic [CNT_W-1:0]      instret;
  logic                  halt;

  always #5 clock = ~clock;

  wb_commit_unit #(
    .XLEN(XLEN), .RF_ADDR_W(RF_ADDR_W), .CSR_ADDR_W(CSR_ADDR_W),
    .CNT_W(CNT_W), .REDIRECT_BUBBLE(BUBBLE)
  ) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_res(in_res), .in_rd_addr(in_rd_addr), .in_rd_wen(in_rd_wen),
    .in_csr_addr(in_csr_addr), .in_csr_wen(in_csr_wen), .in_csr_wdata(in_csr_wdata),
    .in_pc_next(in_pc_next), .in_jump(in_jump), .in_ecall(in_ecall), .in_mret(in_mret),
    .in_ebreak(in_ebreak), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .instret(instret), .halt(halt)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: cycle index, first cycle in which input may be taken, expected outputs.
  int              cyc = 0;
  int              ready_from = 0;
  bit              m_on = 1'b0;
  bit              e_halt = 1'b0;
  bit              e_rf_wen = 1'b0, e_csr_wen = 1'b0, e_redir = 1'b0, e_retire = 1'b0;
  logic [63:0]     e_rf_waddr = '0, e_rf_wdata = '0, e_csr_waddr = '0, e_csr_wdata = '0;
  logic [63:0]     e_redir_pc = '0, e_retire_pc = '0;
  int              e_instret = 0;

  always @(posedge clock) begin
    bit acc;
    if (reset) begin
      m_on = 1'b1;
      e_rf_wen = 0; e_csr_wen = 0; e_redir = 0; e_retire = 0; e_halt = 0;
      e_rf_waddr = 0; e_rf_wdata = 0; e_csr_waddr = 0; e_csr_wdata = 0;
      e_redir_pc = 0; e_retire_pc = 0; e_instret = 0;
      ready_from = cyc + 1;
    end else if (m_on) begin
      acc = in_valid && !e_halt && (cyc >= ready_from);
      e_rf_wen  = acc && in_rd_wen && (in_rd_addr != 0);
      e_csr_wen = acc && in_csr_wen;
      e_redir   = 1'b0;
      e_retire  = acc;
      if (acc) begin
        e_rf_waddr  = 64'(in_rd_addr);
        e_rf_wdata  = 64'(in_res);
        e_csr_waddr = 64'(in_csr_addr);
        e_csr_wdata = 64'(in_csr_wdata);
        e_retire_pc = 64'(in_pc);
        e_instret   = (e_instret + 1) % (1 << CNT_W);
        if (in_ebreak) begin
          e_halt = 1'b1;
        end else if (in_jump || in_ecall || in_mret) begin
          e_redir    = 1'b1;
          e_redir_pc = 64'(in_pc_next);
          ready_from = cyc + 1 + BUBBLE;
        end
      end
    end
    cyc++;
  end

  always @(negedge clock) begin
    #2;
    if (m_on) begin
      chk("in_ready", 64'(in_ready), 64'(!reset && !e_halt && (cyc >= ready_from)));
      chk("rf_wen", 64'(rf_wen), 64'(e_rf_wen));
      if (e_rf_wen) begin
        chk("rf_waddr", 64'(rf_waddr), e_rf_waddr);
        chk("rf_wdata", 64'(rf_wdata), e_rf_wdata);
      end
      chk("csr_wen", 64'(csr_wen), 64'(e_csr_wen));
      if (e_csr_wen) begin
        chk("csr_waddr", 64'(csr_waddr), e_csr_waddr);
        chk("csr_wdata", 64'(csr_wdata), e_csr_wdata);
      end
      chk("redirect_valid", 64'(redirect_valid), 64'(e_redir));
      if (e_redir) chk("redirect_pc", 64'(redirect_pc), e_redir_pc);
      chk("retire_valid", 64'(retire_valid), 64'(e_retire));
      if (e_retire) chk("retire_pc", 64'(retire_pc), e_retire_pc);
      chk("instret", 64'(instret), 64'(e_instret));
      chk("halt", 64'(halt), 64'(e_halt));
    end
  end

  task automatic tick();
    @(negedge clock);
    #3;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [31:0] res,
                           input int rd, input bit rd_wen,
                           input int csr, input bit csr_wen, input logic [31:0] csr_wd,
                           input logic [31:0] pc_next, input bit jump, input bit ebreak);
    in_valid = 1'b1; in_pc = pc; in_res = res;
    in_rd_addr = RF_ADDR_W'(rd); in_rd_wen = rd_wen;
    in_csr_addr = CSR_ADDR_W'(csr); in_csr_wen = csr_wen; in_csr_wdata = csr_wd;
    in_pc_next = pc_next; in_jump = jump; in_ecall = 1'b0; in_mret = 1'b0;
    in_ebreak = ebreak;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_rd_wen = 1'b0; in_csr_wen = 1'b0;
    in_jump = 1'b0; in_ecall = 1'b0; in_mret = 1'b0; in_ebreak = 1'b0;
  endtask

  task automatic rand_instr();
    in_valid     = ($urandom_range(0, 3) != 0);
    in_pc        = $urandom;
    in_res       = $urandom;
    in_rd_addr   = RF_ADDR_W'($urandom);
    in_rd_wen    = $urandom_range(0, 1) == 1;
    in_csr_addr  = CSR_ADDR_W'($urandom);
    in_csr_wen   = ($urandom_range(0, 3) == 0);
    in_csr_wdata = $urandom;
    in_pc_next   = $urandom;
    in_jump      = ($urandom_range(0, 4) == 0);
    in_ecall     = ($urandom_range(0, 15) == 0);
    in_mret      = ($urandom_range(0, 15) == 0);
    in_ebreak    = ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a valid instruction waiting
    reset = 1'b1;
    set_instr(32'h8000_0000, 32'h55, 5, 1'b1, 12'h300, 1'b1, 32'h1, 32'h0, 1'b1, 1'b0);
    repeat (3) tick();
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_retire", 64'(retire_valid), 64'd0);
    chk("rst_redirect", 64'(redirect_valid), 64'd0);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
    reset = 1'b0;
    idle();
    #1;
    chk("ready_after_rst", 64'(in_ready), 64'd1);

    // Back-to-back ALU ops
    set_instr(32'h8000_0000, 32'h11, 5, 1'b1, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("alu0_rf_wen", 64'(rf_wen), 64'd1);
    chk("alu0_waddr", 64'(rf_waddr), 64'd5);
    chk("alu0_wdata", 64'(rf_wdata), 64'h11);
    set_instr(32'h8000_0004, 32'h22, 0, 1'b1, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("alu1_rf_wen_x0", 64'(rf_wen), 64'd0);
    chk("alu1_retire", 64'(retire_valid), 64'd1);
    set_instr(32'h8000_0008, 32'h33, 7, 1'b1, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    set_instr(32'h8000_000c, 32'h44, 2, 1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("alu3_rf_wen", 64'(rf_wen), 64'd0);
    chk("alu3_retire_pc", 64'(retire_pc), 64'h8000_000c);
    chk("alu_instret", 64'(instret), 64'd4);

    // jal with link and a bubble; next instruction held during the bubble
    set_instr(32'h8000_0000, 32'h8000_0004, 1, 1'b1, 0, 1'b0, 0, 32'h8000_0100, 1'b1, 1'b0);
    tick();
    chk("jal_redirect", 64'(redirect_valid), 64'd1);
    chk("jal_redirect_pc", 64'(redirect_pc), 64'h8000_0100);
    chk("jal_link_addr", 64'(rf_waddr), 64'd1);
    chk("jal_link_data", 64'(rf_wdata), 64'h8000_0004);
    chk("jal_ready_t1", 64'(in_ready), 64'd0);
    chk("jal_instret", 64'(instret), 64'd5);
    set_instr(32'h8000_0100, 32'h77, 4, 1'b1, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    tick();
    chk("jal_ready_t2", 64'(in_ready), 64'd0);
    chk("jal_retire_t2", 64'(retire_valid), 64'd0);
    chk("jal_redirect_t2", 64'(redirect_valid), 64'd0);
    tick();
    chk("jal_ready_t3", 64'(in_ready), 64'd1);
    tick();
    chk("held_retire", 64'(retire_valid), 64'd1);
    chk("held_retire_pc", 64'(retire_pc), 64'h8000_0100);
    chk("held_instret", 64'(instret), 64'd6);

    // csrrw: GPR and CSR writes in the same cycle
    set_instr(32'h8000_0104, 32'h0, 3, 1'b1, 12'h305, 1'b1, 32'h1000, 0, 1'b0, 1'b0);
    tick();
    chk("csrrw_rf_wen", 64'(rf_wen), 64'd1);
    chk("csrrw_rf_waddr", 64'(rf_waddr), 64'd3);
    chk("csrrw_rf_wdata", 64'(rf_wdata), 64'd0);
    chk("csrrw_csr_wen", 64'(csr_wen), 64'd1);
    chk("csrrw_csr_waddr", 64'(csr_waddr), 64'h305);
    chk("csrrw_csr_wdata", 64'(csr_wdata), 64'h1000);
    idle();
    tick();
    chk("idle_csr_wen", 64'(csr_wen), 64'd0);

    // Randomized traffic including resets, redirects and ebreaks
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      rand_instr();
      tick();
    end

    // ebreak with in_jump set
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    set_instr(32'h8000_0020, 32'habc, 6, 1'b1, 0, 1'b0, 0, 32'h1234, 1'b1, 1'b1);
    tick();
    chk("ebreak_retire", 64'(retire_valid), 64'd1);
    chk("ebreak_retire_pc", 64'(retire_pc), 64'h8000_0020);
    chk("ebreak_halt", 64'(halt), 64'd1);
    chk("ebreak_redirect", 64'(redirect_valid), 64'd0);
    chk("ebreak_rf_wen", 64'(rf_wen), 64'd1);
    chk("ebreak_instret", 64'(instret), 64'd1);
    set_instr(32'h8000_0024, 32'h1, 7, 1'b1, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("halt_ready", 64'(in_ready), 64'd0);
      tick();
    end
    chk("halt_sticky", 64'(halt), 64'd1);
    reset = 1'b1;
    idle();
    tick();
    chk("halt_cleared", 64'(halt), 64'd0);
    chk("halt_instret_cleared", 64'(instret), 64'd0);
    reset = 1'b0;

    // Retire counter wrap with a 4-bit counter
    for (int i = 1; i <= 17; i++) begin
      set_instr(32'h8000_0000 + 32'(i * 4), 32'(i), 9, 1'b1, 0, 1'b0, 0, 0, 1'b0, 1'b0);
      tick();
      if (i == 15) chk("wrap_15", 64'(instret), 64'hF);
      if (i == 16) chk("wrap_16", 64'(instret), 64'h0);
      if (i == 17) chk("wrap_17", 64'(instret), 64'h1);
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
